pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer_if.sv | 46 ++++
 rtl/pc_sequencer.sv | 168 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Decode-side bundle for pc_sequencer: run control, advance gating, branch/loop/halt
// decode fields, and the registered PC plus status returned to the decoder.
interface pc_sequencer_if #(
  parameter int PC_W       = 12,
  parameter int CNT_W      = 16,
  parameter int LOOP_DEPTH = 4
);
  localparam int LVL_W = $clog2(LOOP_DEPTH + 1);

  logic             start;
  logic [PC_W-1:0]  start_addr;
  logic             is_not_vect;
  logic             done_auto_incr;
  logic             is_vstreamout;
  logic             supplier;
  logic             done_steady;
  logic [1:0]       br_op;
  logic             flag_neq;
  logic [PC_W-1:0]  branch_immediate;
  logic             is_loop;
  logic [CNT_W-1:0] loop_count;
  logic [PC_W-1:0]  loop_end;
  logic             is_halt;

  logic [PC_W-1:0]  pc;
  logic             running;
  logic             pc_step;
  logic             done;
  logic [LVL_W-1:0] loop_level;
  logic             err_loop_ovf;
  logic [1:0]       dbg_state;

  modport master (
    output start, start_addr, is_not_vect, done_auto_incr, is_vstreamout, supplier,
           done_steady, br_op, flag_neq, branch_immediate, is_loop, loop_count,
           loop_end, is_halt,
    input  pc, running, pc_step, done, loop_level, err_loop_ovf, dbg_state
  );

  modport slave (
    input  start, start_addr, is_not_vect, done_auto_incr, is_vstreamout, supplier,
           done_steady, br_op, flag_neq, branch_immediate, is_loop, loop_count,
           loop_end, is_halt,
    output pc, running, pc_step, done, loop_level, err_loop_ovf, dbg_state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Registered PC sequencer: start/halt run FSM, completion-gated advance, BNE/BEQ/JMP,
// and a zero-overhead hardware loop stack.
module pc_sequencer #(
  parameter int PC_W       = 12,
  parameter int CNT_W      = 16,
  parameter int LOOP_DEPTH = 4,
  parameter int REL_BRANCH = 0
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.slave bus
);
  localparam int LVL_W = $clog2(LOOP_DEPTH + 1);
  localparam int IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [PC_W-1:0]  stk_start [LOOP_DEPTH];
  logic [PC_W-1:0]  stk_end   [LOOP_DEPTH];
  logic [CNT_W-1:0] stk_cnt   [LOOP_DEPTH];

  logic             ready;
  logic             step;
  logic             br_taken;
  logic             stk_empty;
  logic             stk_full;
  logic             at_loop_end;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] push_idx;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  br_target;
  logic             do_push;
  logic             do_dec;

  // Handshake: the current instruction is "valid" while RUN; it is accepted (retired)
  // in any cycle where done_steady and ready are both high, and pc_step marks that
  // single-cycle acceptance. Every PC/stack/state change happens only on that edge.
  assign ready = bus.is_not_vect ? 1'b1
                                 : (bus.done_auto_incr & (~bus.is_vstreamout | bus.supplier));
  assign step  = (state_q == ST_RUN) & bus.done_steady & ready;

  assign stk_empty   = (level_q == '0);
  assign stk_full    = (level_q == LVL_W'(LOOP_DEPTH));
  assign top_idx     = IDX_W'(level_q - LVL_W'(1));
  assign push_idx    = IDX_W'(level_q);
  assign at_loop_end = !stk_empty && (pc_q == stk_end[top_idx]);
  assign pc_inc      = pc_q + PC_W'(1);

  // Modulo-2^PC_W addition makes the relative offset behave as sign-extended.
  assign br_target = (REL_BRANCH != 0) ? (pc_q + bus.branch_immediate) : bus.branch_immediate;

  always_comb begin
    br_taken = 1'b0;
    case (bus.br_op)
      2'b01:   br_taken = bus.flag_neq;
      2'b10:   br_taken = ~bus.flag_neq;
      2'b11:   br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    do_push = 1'b0;
    do_dec  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (bus.start) begin
          state_d = ST_RUN;
          pc_d    = bus.start_addr;
          level_d = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (step) begin
          if (bus.is_halt) begin
            state_d = ST_HALTED;
            done_d  = 1'b1;
          end else if (br_taken) begin
            pc_d = br_target;
          end else if (bus.is_loop) begin
            if (bus.loop_count == '0) begin
              pc_d = bus.loop_end + PC_W'(1);
            end else if (stk_full) begin
              ovf_d = 1'b1;
              pc_d  = pc_inc;
            end else begin
              do_push = 1'b1;
              level_d = level_q + LVL_W'(1);
              pc_d    = pc_inc;
            end
          end else if (at_loop_end) begin
            // Loop-back loads the body start directly, so iteration costs no bubble.
            if (stk_cnt[top_idx] > CNT_W'(1)) begin
              do_dec = 1'b1;
              pc_d   = stk_start[top_idx];
            end else begin
              level_d = level_q - LVL_W'(1);
              pc_d    = pc_inc;
            end
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Entry payload needs no reset: entries above loop_level are never read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_push) begin
        stk_start[push_idx] <= pc_inc;
        stk_end[push_idx]   <= bus.loop_end;
        stk_cnt[push_idx]   <= bus.loop_count;
      end else if (do_dec) begin
        stk_cnt[top_idx] <= stk_cnt[top_idx] - CNT_W'(1);
      end
    end
  end

  assign bus.pc           = pc_q;
  assign bus.running      = (state_q == ST_RUN);
  assign bus.pc_step      = step;
  assign bus.done         = done_q;
  assign bus.loop_level   = level_q;
  assign bus.err_loop_ovf = ovf_q;
  assign bus.dbg_state    = state_q;

`ifndef SYNTHESIS
  level_bounded: assert property (@(posedge clk) disable iff (rst)
    level_q <= LVL_W'(LOOP_DEPTH));
  done_single: assert property (@(posedge clk) disable iff (rst)
    done_q |=> !done_q);
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: absolute- and relative-branch instances share stimulus and
// are compared each cycle against a queue-based sequencing model.
module tb_pc_sequencer;
  localparam int PC_W  = 12;
  localparam int CNT_W = 16;
  localparam int DEPTH = 4;
  localparam int SPAN  = 1 << PC_W;
  localparam int HALF  = SPAN / 2;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  typedef struct {
    int s;
    int e;
    int c;
  } loop_t;

  logic clk = 1'b0;
  logic rst;
  logic start, is_not_vect, done_auto_incr, is_vstreamout, supplier, done_steady;
  logic flag_neq, is_loop, is_halt;
  logic [PC_W-1:0]  start_addr, branch_immediate, loop_end;
  logic [1:0]       br_op;
  logic [CNT_W-1:0] loop_count;

  int n_checks = 0;
  int n_pass   = 0;

  int    m_state [2];
  int    m_pc    [2];
  int    m_lvl   [2];
  bit    m_ovf   [2];
  bit    m_done  [2];
  loop_t stk0 [$];
  loop_t stk1 [$];

  logic [PC_W-1:0] exp_q [$];
  int lvl_exp [7] = '{1, 1, 1, 1, 1, 1, 0};

  // ---------------- clock / reset / DUTs ----------------
  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W), .LOOP_DEPTH(DEPTH)) bus0 ();
  pc_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W), .LOOP_DEPTH(DEPTH)) bus1 ();

  pc_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .LOOP_DEPTH(DEPTH), .REL_BRANCH(0))
    dut_abs (.clk(clk), .rst(rst), .bus(bus0));
  pc_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .LOOP_DEPTH(DEPTH), .REL_BRANCH(1))
    dut_rel (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.start = start;                       assign bus1.start = start;
  assign bus0.start_addr = start_addr;             assign bus1.start_addr = start_addr;
  assign bus0.is_not_vect = is_not_vect;           assign bus1.is_not_vect = is_not_vect;
  assign bus0.done_auto_incr = done_auto_incr;     assign bus1.done_auto_incr = done_auto_incr;
  assign bus0.is_vstreamout = is_vstreamout;       assign bus1.is_vstreamout = is_vstreamout;
  assign bus0.supplier = supplier;                 assign bus1.supplier = supplier;
  assign bus0.done_steady = done_steady;           assign bus1.done_steady = done_steady;
  assign bus0.br_op = br_op;                       assign bus1.br_op = br_op;
  assign bus0.flag_neq = flag_neq;                 assign bus1.flag_neq = flag_neq;
  assign bus0.branch_immediate = branch_immediate; assign bus1.branch_immediate = branch_immediate;
  assign bus0.is_loop = is_loop;                   assign bus1.is_loop = is_loop;
  assign bus0.loop_count = loop_count;             assign bus1.loop_count = loop_count;
  assign bus0.loop_end = loop_end;                 assign bus1.loop_end = loop_end;
  assign bus0.is_halt = is_halt;                   assign bus1.is_halt = is_halt;

  // ---------------- checking ----------------
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic sb_pc(input string tag);
    logic [PC_W-1:0] e;
    e = exp_q.pop_front();
    check(tag, int'(bus0.pc), int'(e));
  endtask

  // ---------------- reference model ----------------
  function automatic bit exp_step(input int d);
    bit rdy;
    rdy = is_not_vect ? 1'b1 : (done_auto_incr && (!is_vstreamout || supplier));
    return (m_state[d] == M_RUN) && done_steady && rdy;
  endfunction

  task automatic model_edge(input int d);
    loop_t q [$];
    loop_t ent;
    bit    stp;
    bit    taken;
    int    off;
    stp   = exp_step(d);
    taken = (br_op == 2'd1 && flag_neq) || (br_op == 2'd2 && !flag_neq) || (br_op == 2'd3);
    if (d == 0) q = stk0; else q = stk1;
    m_done[d] = 1'b0;
    if (rst) begin
      m_state[d] = M_IDLE; m_pc[d] = 0; m_ovf[d] = 1'b0; q.delete();
    end else if (m_state[d] != M_RUN) begin
      if (start) begin
        m_state[d] = M_RUN; m_pc[d] = int'(start_addr); m_ovf[d] = 1'b0; q.delete();
      end
    end else if (stp) begin
      if (is_halt) begin
        m_state[d] = M_HALT; m_done[d] = 1'b1;
      end else if (taken) begin
        if (d == 1) begin
          off = int'(branch_immediate);
          if (off >= HALF) off -= SPAN;
          m_pc[d] = (m_pc[d] + off + SPAN) % SPAN;
        end else begin
          m_pc[d] = int'(branch_immediate);
        end
      end else if (is_loop) begin
        if (loop_count == 0) begin
          m_pc[d] = (int'(loop_end) + 1) % SPAN;
        end else if (q.size() == DEPTH) begin
          m_ovf[d] = 1'b1; m_pc[d] = (m_pc[d] + 1) % SPAN;
        end else begin
          ent.s = (m_pc[d] + 1) % SPAN; ent.e = int'(loop_end); ent.c = int'(loop_count);
          q.push_back(ent);
          m_pc[d] = (m_pc[d] + 1) % SPAN;
        end
      end else if (q.size() > 0 && q[q.size()-1].e == m_pc[d]) begin
        ent = q[q.size()-1];
        if (ent.c > 1) begin
          ent.c--; q[q.size()-1] = ent; m_pc[d] = ent.s;
        end else begin
          void'(q.pop_back()); m_pc[d] = (m_pc[d] + 1) % SPAN;
        end
      end else begin
        m_pc[d] = (m_pc[d] + 1) % SPAN;
      end
    end
    m_lvl[d] = q.size();
    if (d == 0) stk0 = q; else stk1 = q;
  endtask

  // ---------------- driver tasks ----------------
  task automatic defaults();
    rst = 1'b0; start = 1'b0; start_addr = '0;
    is_not_vect = 1'b1; done_auto_incr = 1'b0; is_vstreamout = 1'b0; supplier = 1'b0;
    done_steady = 1'b1; br_op = 2'd0; flag_neq = 1'b0; branch_immediate = '0;
    is_loop = 1'b0; loop_count = '0; loop_end = '0; is_halt = 1'b0;
  endtask

  task automatic check_outputs();
    check("pc_abs", int'(bus0.pc), m_pc[0]);
    check("pc_rel", int'(bus1.pc), m_pc[1]);
    check("running_abs", int'(bus0.running), int'(m_state[0] == M_RUN));
    check("running_rel", int'(bus1.running), int'(m_state[1] == M_RUN));
    check("level_abs", int'(bus0.loop_level), m_lvl[0]);
    check("level_rel", int'(bus1.loop_level), m_lvl[1]);
    check("ovf_abs", int'(bus0.err_loop_ovf), int'(m_ovf[0]));
    check("ovf_rel", int'(bus1.err_loop_ovf), int'(m_ovf[1]));
    check("done_abs", int'(bus0.done), int'(m_done[0]));
    check("done_rel", int'(bus1.done), int'(m_done[1]));
  endtask

  // One clock: check combinational pc_step, take the edge, advance model, check state.
  task automatic cycle();
    #1;
    check("step_abs", int'(bus0.pc_step), int'(exp_step(0)));
    check("step_rel", int'(bus1.pc_step), int'(exp_step(1)));
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_outputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      m_state[d] = M_IDLE; m_pc[d] = 0; m_lvl[d] = 0; m_ovf[d] = 1'b0; m_done[d] = 1'b0;
    end
    defaults();
    rst = 1'b1;
    @(posedge clk);
    model_edge(0); model_edge(1);
    #1;
    check_outputs();
    cycle();
    check("rst_pc", int'(bus0.pc), 0);
    check("rst_running", int'(bus0.running), 0);
    check("rst_level", int'(bus0.loop_level), 0);
    check("rst_step", int'(bus0.pc_step), 0);

    // start and scalar stream
    defaults();
    exp_q.push_back(12'h010); exp_q.push_back(12'h011); exp_q.push_back(12'h012);
    start = 1'b1; start_addr = 12'h010; cycle(); sb_pc("start_pc");
    defaults();
    cycle(); sb_pc("scalar_pc");
    cycle(); sb_pc("scalar_pc");

    // vector and vstreamout gating
    is_not_vect = 1'b0; done_auto_incr = 1'b0;
    repeat (5) cycle();
    check("vec_hold", int'(bus0.pc), 12'h012);
    is_vstreamout = 1'b1; done_auto_incr = 1'b1; supplier = 1'b0; cycle();
    check("vso_hold", int'(bus0.pc), 12'h012);
    supplier = 1'b1; cycle();
    check("vso_step", int'(bus0.pc), 12'h013);

    // branches
    defaults(); br_op = 2'd1; flag_neq = 1'b1; branch_immediate = 12'h020; cycle();
    check("bne_abs", int'(bus0.pc), 12'h020);
    check("bne_rel", int'(bus1.pc), 12'h033);
    flag_neq = 1'b0; cycle();
    check("bne_not_taken", int'(bus0.pc), 12'h021);
    br_op = 2'd2; branch_immediate = 12'h040; cycle();
    check("beq_taken", int'(bus0.pc), 12'h040);
    defaults(); done_steady = 1'b0; start = 1'b1; start_addr = 12'h100; cycle();
    check("start_in_run", int'(bus0.pc), 12'h040);

    // halt
    defaults(); br_op = 2'd3; branch_immediate = 12'h030; cycle();
    check("jmp_abs", int'(bus0.pc), 12'h030);
    defaults(); is_halt = 1'b1; cycle();
    check("halt_done", int'(bus0.done), 1);
    check("halt_pc", int'(bus0.pc), 12'h030);
    defaults(); cycle();
    check("halt_done_clr", int'(bus0.done), 0);
    check("halted_running", int'(bus0.running), 0);

    // relative branch and wrap
    start = 1'b1; start_addr = 12'h005; cycle();
    defaults(); br_op = 2'd1; flag_neq = 1'b1; branch_immediate = 12'hFFE; cycle();
    check("rel_back", int'(bus1.pc), 12'h003);
    check("abs_far", int'(bus0.pc), 12'hFFE);
    defaults(); cycle(); cycle();
    check("pc_wrap", int'(bus0.pc), 12'h000);

    // hardware loop
    is_halt = 1'b1; cycle();
    defaults(); start = 1'b1; start_addr = 12'h004; cycle();
    for (int i = 0; i < 7; i++) exp_q.push_back(PC_W'(i % 2 == 0 ? 5 : 6));
    exp_q[6] = 12'h007;
    for (int i = 0; i < 7; i++) begin
      defaults();
      if (i == 0) begin is_loop = 1'b1; loop_count = 16'd3; loop_end = 12'h006; end
      cycle();
      sb_pc("loop_pc");
      check("loop_lvl", int'(bus0.loop_level), lvl_exp[i]);
    end
    defaults(); is_loop = 1'b1; loop_count = 16'd0; loop_end = 12'h00A; cycle();
    check("loop_zero_pc", int'(bus0.pc), 12'h00B);
    check("loop_zero_lvl", int'(bus0.loop_level), 0);

    // stack overflow
    for (int i = 0; i < 5; i++) begin
      defaults(); is_loop = 1'b1; loop_count = 16'd2; loop_end = 12'h200; cycle();
    end
    check("ovf_level", int'(bus0.loop_level), 4);
    check("ovf_flag", int'(bus0.err_loop_ovf), 1);
    defaults(); repeat (3) cycle();
    is_halt = 1'b1; cycle();
    check("ovf_sticky", int'(bus0.err_loop_ovf), 1);
    defaults(); start = 1'b1; start_addr = 12'h004; cycle();
    check("ovf_clear", int'(bus0.err_loop_ovf), 0);
    check("start_lvl", int'(bus0.loop_level), 0);

    // reset mid-loop beats step and start
    defaults(); is_loop = 1'b1; loop_count = 16'd5; loop_end = 12'h006; cycle();
    defaults(); cycle();
    rst = 1'b1; start = 1'b1; start_addr = 12'h077; cycle();
    check("rst_mid_pc", int'(bus0.pc), 0);
    check("rst_mid_lvl", int'(bus0.loop_level), 0);
    check("rst_mid_run", int'(bus0.running), 0);

    // randomized phase
    for (int n = 0; n < 4000; n++) begin
      rst              = ($urandom_range(0, 399) == 0);
      start            = ($urandom_range(0, 11) == 0);
      start_addr       = ($urandom_range(0, 3) == 0) ? PC_W'($urandom_range(4088, 4095))
                                                     : PC_W'($urandom_range(0, 4095));
      is_not_vect      = ($urandom_range(0, 2) != 0);
      done_auto_incr   = 1'($urandom_range(0, 1));
      is_vstreamout    = 1'($urandom_range(0, 1));
      supplier         = 1'($urandom_range(0, 1));
      done_steady      = ($urandom_range(0, 4) != 0);
      br_op            = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      flag_neq         = 1'($urandom_range(0, 1));
      branch_immediate = ($urandom_range(0, 1) == 0) ? PC_W'($urandom_range(0, 4095))
                                                     : PC_W'(SPAN - $urandom_range(1, 8));
      is_loop          = ($urandom_range(0, 4) == 0);
      loop_count       = CNT_W'($urandom_range(0, 3));
      loop_end         = PC_W'(m_pc[0] + int'($urandom_range(0, 5)));
      is_halt          = ($urandom_range(0, 80) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
